gcd_job_sequencer: RTL and testbench
====================================

GCD_JOB_SEQUENCER -- requirements
Module: gcd_job_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, operand/result width.
REQ-002 Parameter: FIFO_DEPTH, 4, job FIFO entries (power of 2, >=2).
REQ-003 Parameter: TIMEOUT_CYCLES, 512, maximum WAIT cycles before error.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 in_valid_i  in  1  job offered.
REQ-008 in_a_i, in_b_i  in  DATA_WIDTH each  job operands.
REQ-009 in_ready_o  out  1  FIFO can accept a job.
REQ-010 operand_a_o, operand_b_o  out  DATA_WIDTH each  operands to GCD engine, registered.
REQ-011 gcd_enable_o  out  1  GCD engine start/hold, registered.
REQ-012 gcd_i  in  DATA_WIDTH  engine result.
REQ-013 gcd_done_i  in  1  engine result valid.
REQ-014 out_valid_o  out  1  result available.
REQ-015 out_ready_i  in  1  downstream accepts result.
REQ-016 out_gcd_o  out  DATA_WIDTH  result value.
REQ-017 out_err_o  out  1  result invalid (zero operands or timeout).
REQ-018 fifo_count_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-019 Push occurs when in_valid_i && in_ready_o; in_ready_o = (fifo_count_o != FIFO_DEPTH) && !reset_i, independent of same-cycle pop.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH; push when full is impossible by REQ-019.
REQ-021 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE: if count>0, pop head into operand_a_o/operand_b_o; if both operands zero go HOLD with out_gcd_o=0, out_err_o=1; else go ISSUE. If count==0 stay IDLE.
REQ-023 ISSUE: gcd_enable_o=1; next state WAIT; watchdog counter cleared.
REQ-024 WAIT: gcd_enable_o stays 1; on gcd_done_i=1 capture gcd_i into out_gcd_o, out_err_o=0, drop gcd_enable_o, go HOLD.
REQ-025 WAIT: watchdog increments each cycle without gcd_done_i; at count TIMEOUT_CYCLES-1 go HOLD with out_gcd_o=0, out_err_o=1, gcd_enable_o=0.
REQ-026 HOLD: out_valid_o=1; out_gcd_o/out_err_o stable until out_valid_o && out_ready_i; then out_valid_o=0 and go IDLE.
REQ-027 gcd_done_i outside WAIT SHALL be ignored.
REQ-028 operand_a_o/operand_b_o SHALL be stable from pop until the job leaves HOLD.
REQ-029 Latency: job pushed at cycle t into empty FIFO with FSM IDLE -> popped t+1, gcd_enable_o=1 at t+2.
REQ-030 One job in flight at a time; next pop no earlier than the cycle after the HOLD handshake.

Reset
REQ-031 While reset_i high at a clock edge: state IDLE, FIFO flushed (count 0), pointers 0, watchdog 0.
REQ-032 Reset values: gcd_enable_o=0, operand_a_o=0, operand_b_o=0, out_valid_o=0, out_gcd_o=0, out_err_o=0, fifo_count_o=0, in_ready_o=0 during reset.
REQ-033 Reset mid-job SHALL discard the job and any pending result; a late gcd_done_i after reset SHALL produce no output.

Verification
REQ-034 Push (12,18); engine model returns 6 after 5 cycles -> gcd_enable_o=1 at t+2 with operands 12/18; out_valid_o=1, out_gcd_o=6, out_err_o=0.
REQ-035 out_ready_i=0, push 5 jobs back-to-back -> first popped, then 4 fill FIFO; fifo_count_o=4, in_ready_o=0, 6th push blocked; drain all -> results in push order.
REQ-036 Push (0,0) -> gcd_enable_o never asserted; out_valid_o=1 two cycles after push, out_gcd_o=0, out_err_o=1.
REQ-037 Push (7,0) with engine never asserting done -> after 512 WAIT cycles out_err_o=1, out_gcd_o=0, gcd_enable_o=0.
REQ-038 Assert reset_i during WAIT, then model drives gcd_done_i -> next cycle all outputs 0, fifo_count_o=0; out_valid_o stays 0.
REQ-039 Result held with out_ready_i=0 for 10 cycles -> out_valid_o, out_gcd_o, out_err_o unchanged every cycle; accepted on first cycle out_ready_i=1.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// GCD job sequencer: buffers operand pairs in a small FIFO, issues them one at
// a time to an external GCD engine, guards each job with a watchdog, and holds
// the result (or an error for zero operands / timeout) until it is accepted.
module gcd_job_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          in_valid_i,
    input  logic [DATA_WIDTH-1:0]         in_a_i,
    input  logic [DATA_WIDTH-1:0]         in_b_i,
    output logic                          in_ready_o,
    output logic [DATA_WIDTH-1:0]         operand_a_o,
    output logic [DATA_WIDTH-1:0]         operand_b_o,
    output logic                          gcd_enable_o,
    input  logic [DATA_WIDTH-1:0]         gcd_i,
    input  logic                          gcd_done_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_gcd_o,
    output logic                          out_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_b [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [TW-1:0]           wdog;
    logic                    push, pop;
    logic                    head_zero;
    logic                    wdog_expired;

    assign in_ready_o   = (fifo_count_o != CW'(FIFO_DEPTH)) && !reset_i;
    assign push         = in_valid_i && in_ready_o;
    assign head_zero    = (mem_a[rd_ptr] == '0) && (mem_b[rd_ptr] == '0);
    assign wdog_expired = (wdog == TW'(TIMEOUT_CYCLES - 1));

    // Job storage; written only on an accepted push.
    // NOTE: the storage array has no reset -- occupancy is tracked by the pointers and count, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a_i;
            mem_b[wr_ptr] <= in_b_i;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count_o <= fifo_count_o + CW'(1);
                2'b01:   fifo_count_o <= fifo_count_o - CW'(1);
                default: fifo_count_o <= fifo_count_o;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic and pop decision.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count_o != '0) begin
                    pop        = 1'b1;
                    state_next = head_zero ? HOLD : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (gcd_done_i || wdog_expired) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered engine interface, watchdog and result holding registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            operand_a_o  <= '0;
            operand_b_o  <= '0;
            gcd_enable_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_gcd_o    <= '0;
            out_err_o    <= 1'b0;
            wdog         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        operand_a_o <= mem_a[rd_ptr];
                        operand_b_o <= mem_b[rd_ptr];
                        if (head_zero) begin
                            out_gcd_o   <= '0;
                            out_err_o   <= 1'b1;
                            out_valid_o <= 1'b1;
                        end else begin
                            gcd_enable_o <= 1'b1;
                        end
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    if (gcd_done_i) begin
                        out_gcd_o    <= gcd_i;
                        out_err_o    <= 1'b0;
                        out_valid_o  <= 1'b1;
                        gcd_enable_o <= 1'b0;
                    end else if (wdog_expired) begin
                        out_gcd_o    <= '0;
                        out_err_o    <= 1'b1;
                        out_valid_o  <= 1'b1;
                        gcd_enable_o <= 1'b0;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready_i) out_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer: table-driven vectors, directed
// corner-case sequences and randomized traffic checked by a queue-based model.
module tb_gcd_job_sequencer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 512;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic                    in_valid_i;
    logic [DW-1:0]           in_a_i, in_b_i;
    logic                    in_ready_o;
    logic [DW-1:0]           operand_a_o, operand_b_o;
    logic                    gcd_enable_o;
    logic [DW-1:0]           gcd_i = '0;
    logic                    gcd_done_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [DW-1:0]           out_gcd_o;
    logic                    out_err_o;
    logic [$clog2(DEPTH):0]  fifo_count_o;

    gcd_job_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_a_i(in_a_i), .in_b_i(in_b_i), .in_ready_o(in_ready_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .gcd_enable_o(gcd_enable_o),
        .gcd_i(gcd_i), .gcd_done_i(gcd_done_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_gcd_o(out_gcd_o), .out_err_o(out_err_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    typedef struct { logic [DW-1:0] g; logic e; } result_t;
    typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] g; logic e; } vec_t;

    result_t exp_q[$];

    // Engine model: a result appears a number of enabled cycles after start.
    int   eng_cnt    = 0;
    int   eng_lat    = 3;
    int   fixed_lat  = 3;
    bit   eng_mute   = 1'b0;
    bit   force_done = 1'b0;
    logic eng_done   = 1'b0;

    assign gcd_done_i = eng_done | force_done;

    always @(negedge clk_i) begin
        if (gcd_enable_o && !eng_mute) begin
            if (eng_cnt == 0) eng_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 7));
            eng_cnt++;
            eng_done = (eng_cnt == eng_lat);
            gcd_i    = DW'(ref_gcd(int'(operand_a_o), int'(operand_b_o)));
        end else begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end
    end

    function automatic result_t expect_of(input logic [DW-1:0] a, input logic [DW-1:0] b);
        result_t r;
        if ((a == 0 && b == 0) || eng_mute) begin
            r.g = '0;
            r.e = 1'b1;
        end else begin
            r.g = DW'(ref_gcd(int'(a), int'(b)));
            r.e = 1'b0;
        end
        return r;
    endfunction

    // Reference model: expected results queued at push, compared in order at
    // each output handshake; held results must not change until accepted.
    bit      hold_seen = 1'b0;
    result_t held;

    always @(negedge clk_i) begin
        result_t r;
        if (reset_i) begin
            hold_seen = 1'b0;
        end else begin
            if (in_valid_i && in_ready_o) exp_q.push_back(expect_of(in_a_i, in_b_i));
            if (hold_seen) begin
                check("hold_valid_stable", out_valid_o, 1);
                check("hold_gcd_stable", out_gcd_o, held.g);
                check("hold_err_stable", out_err_o, held.e);
            end
            if (out_valid_o) begin
                held.g    = out_gcd_o;
                held.e    = out_err_o;
                hold_seen = !out_ready_i;
                if (out_ready_i) begin
                    check("result_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        r = exp_q.pop_front();
                        check("model_gcd", out_gcd_o, r.g);
                        check("model_err", out_err_o, r.e);
                    end
                end
            end else begin
                hold_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_job(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int budget = 2000;
        in_a_i     = a;
        in_b_i     = b;
        in_valid_i = 1'b1;
        while (!in_ready_o && budget > 0) begin
            tick();
            budget--;
        end
        check("push_accepted", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int budget = limit;
        while (!out_valid_o && budget > 0) begin
            tick();
            budget--;
        end
        check("wait_out_valid", out_valid_o, 1);
    endtask

    task automatic drain(input int limit);
        int budget = limit;
        while ((exp_q.size() != 0 || out_valid_o || fifo_count_o != 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, gcd_enable_o, 0);
        check({tag, "_op_a"}, operand_a_o, 0);
        check({tag, "_op_b"}, operand_b_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_out_gcd"}, out_gcd_o, 0);
        check({tag, "_out_err"}, out_err_o, 0);
        check({tag, "_count"}, fifo_count_o, 0);
        check({tag, "_in_ready"}, in_ready_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        int   en_cycles;

        vecs[0] = '{a: 12,  b: 18,  g: 6,   e: 0};
        vecs[1] = '{a: 0,   b: 0,   g: 0,   e: 1};
        vecs[2] = '{a: 7,   b: 0,   g: 7,   e: 0};
        vecs[3] = '{a: 0,   b: 5,   g: 5,   e: 0};
        vecs[4] = '{a: 255, b: 17,  g: 17,  e: 0};
        vecs[5] = '{a: 100, b: 75,  g: 25,  e: 0};
        vecs[6] = '{a: 1,   b: 1,   g: 1,   e: 0};
        vecs[7] = '{a: 128, b: 96,  g: 32,  e: 0};
        vecs[8] = '{a: 200, b: 200, g: 200, e: 0};
        vecs[9] = '{a: 13,  b: 255, g: 1,   e: 0};

        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        in_a_i      = '0;
        in_b_i      = '0;
        out_ready_i = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_i = 1'b0;
        tick();
        check("ready_after_reset", in_ready_o, 1);

        // Table-driven jobs, one at a time, result accepted immediately.
        out_ready_i = 1'b1;
        fixed_lat   = 3;
        for (int i = 0; i < 10; i++) begin
            push_job(vecs[i].a, vecs[i].b);
            wait_valid(50);
            check($sformatf("vec%0d_gcd", i), out_gcd_o, vecs[i].g);
            check($sformatf("vec%0d_err", i), out_err_o, vecs[i].e);
            tick();
            tick();
        end

        // Issue latency: push at t, pop at t+1, enable with operands at t+2.
        fixed_lat  = 5;
        in_a_i     = 8'd12;
        in_b_i     = 8'd18;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("lat_count_after_push", fifo_count_o, 1);
        check("lat_enable_early", gcd_enable_o, 0);
        tick();
        check("lat_enable", gcd_enable_o, 1);
        check("lat_op_a", operand_a_o, 12);
        check("lat_op_b", operand_b_o, 18);
        check("lat_count_after_pop", fifo_count_o, 0);
        wait_valid(50);
        check("lat_gcd", out_gcd_o, 6);
        check("lat_err", out_err_o, 0);
        tick();
        tick();

        // Zero operands: error result two cycles after push, engine never enabled.
        in_a_i     = '0;
        in_b_i     = '0;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("zero_enable_1", gcd_enable_o, 0);
        check("zero_valid_early", out_valid_o, 0);
        tick();
        check("zero_enable_2", gcd_enable_o, 0);
        check("zero_valid", out_valid_o, 1);
        check("zero_gcd", out_gcd_o, 0);
        check("zero_err", out_err_o, 1);
        tick();
        tick();

        // Result held for 10 cycles under back-pressure.
        out_ready_i = 1'b0;
        fixed_lat   = 3;
        push_job(8'd21, 8'd14);
        wait_valid(50);
        for (int i = 0; i < 10; i++) begin
            check("held_valid", out_valid_o, 1);
            check("held_gcd", out_gcd_o, 7);
            check("held_err", out_err_o, 0);
            tick();
        end
        out_ready_i = 1'b1;
        check("held_valid_at_accept", out_valid_o, 1);
        tick();
        check("held_released", out_valid_o, 0);
        tick();

        // FIFO fill: five back-to-back jobs with the output stalled.
        out_ready_i = 1'b0;
        fixed_lat   = 2;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a_i = DW'(8'd10 + 8'(i) * 8'd6);
            in_b_i = (i == 4) ? 8'd0 : DW'(8'd4 + 8'(i) * 8'd2);
            if (i == 4) in_a_i = 8'd0;
            check("fill_ready", in_ready_o, 1);
            tick();
        end
        in_a_i = 8'd3;
        in_b_i = 8'd3;
        for (int i = 0; i < 3; i++) begin
            check("full_count", fifo_count_o, DEPTH);
            check("full_ready", in_ready_o, 0);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain(200);
        tick();

        // Watchdog: engine never answers.
        eng_mute  = 1'b1;
        en_cycles = 0;
        push_job(8'd7, 8'd0);
        for (int budget = 0; budget < 1000 && !out_valid_o; budget++) begin
            if (gcd_enable_o) en_cycles++;
            tick();
        end
        check("timeout_valid", out_valid_o, 1);
        check("timeout_enable_cycles", en_cycles, TO + 1);
        check("timeout_gcd", out_gcd_o, 0);
        check("timeout_err", out_err_o, 1);
        check("timeout_enable_dropped", gcd_enable_o, 0);
        tick();
        eng_mute = 1'b0;
        tick();

        // Reset during WAIT followed by a late done pulse.
        eng_mute = 1'b1;
        push_job(8'd9, 8'd6);
        repeat (4) tick();
        check("rst_mid_enable", gcd_enable_o, 1);
        reset_i    = 1'b1;
        force_done = 1'b1;
        exp_q.delete();
        tick();
        check_reset_outputs("rst_mid");
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_late_done_valid", out_valid_o, 0);
            check("rst_late_done_enable", gcd_enable_o, 0);
        end
        force_done = 1'b0;
        eng_mute   = 1'b0;

        // Randomized traffic against the queue model.
        fixed_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            in_valid_i  = ($urandom_range(0, 1) == 1);
            in_a_i      = ($urandom_range(0, 7) == 0) ? 8'd0 : DW'($urandom_range(1, 255));
            in_b_i      = ($urandom_range(0, 7) == 0) ? 8'd0 : DW'($urandom_range(1, 255));
            out_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
